// File: rtl/systolic_ws_feeder.sv
// Weight-stationary feeder: loads W weight rows, streams K activation
// rows into the array, flushes it, and tags which column-0 sums are real.
module systolic_ws_feeder #(
  parameter int SYSTOLIC_WIDTH = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int SUM_WIDTH      = 16,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 cmd_valid,
  output logic                                 cmd_ready,
  input  logic [CNT_WIDTH-1:0]                 cmd_rows,
  input  logic                                 w_valid,
  output logic                                 w_ready,
  input  logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] w_data,
  input  logic                                 x_valid,
  output logic                                 x_ready,
  input  logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] x_data,
  output logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] a_in_raw,
  output logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] b_in_raw,
  output logic [SYSTOLIC_WIDTH*SUM_WIDTH-1:0]  sum_in_raw,
  output logic                                 mode,
  output logic                                 state,
  output logic                                 res_valid,
  output logic                                 busy,
  output logic                                 done
);

  localparam int W   = SYSTOLIC_WIDTH;
  localparam int WCW = $clog2(W + 1);
  localparam int FCW = $clog2(2 * W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_COMPUTE,
    S_FLUSH
  } fsm_t;

  fsm_t                 fsm_q;
  fsm_t                 fsm_d;
  logic [CNT_WIDTH-1:0] k_q;
  logic [CNT_WIDTH-1:0] xcnt_q;
  logic [WCW-1:0]       wcnt_q;
  logic [FCW-1:0]       fcnt_q;
  logic                 a_vld_q;
  logic [W:0]           tag_q;
  logic                 done_d;
  logic                 w_acc;
  logic                 x_acc;

  assign sum_in_raw = '0;
  assign mode       = 1'b0;
  assign res_valid  = tag_q[W];
  assign w_acc      = w_valid && w_ready;
  assign x_acc      = x_valid && x_ready;

  always_comb begin
    fsm_d     = fsm_q;
    cmd_ready = 1'b0;
    w_ready   = 1'b0;
    x_ready   = 1'b0;
    busy      = 1'b1;
    done_d    = 1'b0;
    unique case (fsm_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) fsm_d = S_LOAD;
      end
      S_LOAD: begin
        w_ready = 1'b1;
        if (w_valid && wcnt_q == WCW'(W - 1))
          fsm_d = S_SETTLE;
      end
      S_SETTLE: begin
        fsm_d = (k_q == '0) ? S_FLUSH : S_COMPUTE;
      end
      S_COMPUTE: begin
        x_ready = (xcnt_q < k_q);
        if (xcnt_q >= k_q)
          fsm_d = S_FLUSH;
        else if (x_valid &&
                 (xcnt_q + CNT_WIDTH'(1)) == k_q)
          fsm_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (fcnt_q == FCW'(2 * W - 1)) begin
          fsm_d  = S_IDLE;
          done_d = 1'b1;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q    <= S_IDLE;
      k_q      <= '0;
      xcnt_q   <= '0;
      wcnt_q   <= '0;
      fcnt_q   <= '0;
      a_in_raw <= '0;
      b_in_raw <= '0;
      state    <= 1'b0;
      a_vld_q  <= 1'b0;
      tag_q    <= '0;
      done     <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      done     <= done_d;
      a_in_raw <= x_acc ? x_data : '0;
      b_in_raw <= w_acc ? w_data : '0;
      state    <= (fsm_q == S_COMPUTE) ||
                  (fsm_q == S_FLUSH);
      // tags start from the cycle a row sits on a_in_raw
      a_vld_q  <= x_acc;
      tag_q    <= {tag_q[W-1:0], a_vld_q};
      if (fsm_q == S_IDLE && cmd_valid) begin
        k_q    <= cmd_rows;
        xcnt_q <= '0;
        wcnt_q <= '0;
        fcnt_q <= '0;
      end
      if (w_acc) wcnt_q <= wcnt_q + WCW'(1);
      if (x_acc) xcnt_q <= xcnt_q + CNT_WIDTH'(1);
      if (fsm_q == S_FLUSH) fcnt_q <= fcnt_q + FCW'(1);
    end
  end

endmodule

// File: tb/tb_systolic_ws_feeder.sv
// Bench for systolic_ws_feeder: scenario table, timeline reference
// model, per-cycle output compare and an end-to-end dot-product check.
module tb_systolic_ws_feeder;

  localparam int W  = 4;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int N  = 80;
  localparam int NA = N + W + 4;

  typedef logic [63:0] mat_t [W];

  typedef struct {
    int k;
    int kind;
    int gap_at;
    int gap;
    int wbub;
    bit hold;
    int exp_busy;
    int exp_rv;
    int exp_done;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [CW-1:0] cmd_rows;
  logic          w_valid;
  logic          w_ready;
  logic [63:0]   w_data;
  logic          x_valid;
  logic          x_ready;
  logic [63:0]   x_data;
  logic [63:0]   a_in_raw;
  logic [63:0]   b_in_raw;
  logic [63:0]   sum_in_raw;
  logic          mode;
  logic          state;
  logic          res_valid;
  logic          busy;
  logic          done;

  systolic_ws_feeder #(
    .SYSTOLIC_WIDTH(W),
    .DATA_WIDTH(DW),
    .SUM_WIDTH(16),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_rows(cmd_rows),
    .w_valid(w_valid),
    .w_ready(w_ready),
    .w_data(w_data),
    .x_valid(x_valid),
    .x_ready(x_ready),
    .x_data(x_data),
    .a_in_raw(a_in_raw),
    .b_in_raw(b_in_raw),
    .sum_in_raw(sum_in_raw),
    .mode(mode),
    .state(state),
    .res_valid(res_valid),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  bit            cv [NA];
  logic [CW-1:0] cr [NA];
  bit            wv [NA];
  bit            xv [NA];
  logic [63:0]   wd [NA];
  logic [63:0]   xd [NA];

  bit          e_wr [NA];
  bit          e_xr [NA];
  bit          e_bz [NA];
  bit          e_dn [NA];
  bit          e_st [NA];
  bit          e_rv [NA];
  logic [63:0] e_a  [NA];
  logic [63:0] e_b  [NA];

  logic [63:0] r_a  [NA];
  logic [63:0] r_b  [NA];
  bit          r_rv [NA];

  mat_t        wrow;
  logic [63:0] xrow [8];
  logic [63:0] yq [$];
  int          bcyc [W];
  vec_t        tbl [8];

  task automatic chk(input string nm, input int cyc,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc %0d: got %0h expected %0h",
               nm, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(int k, int kind, int gat,
                              int gap, int wbub, bit hold,
                              int eb, int erv, int edn);
    vec_t v;
    v.k = k; v.kind = kind; v.gap_at = gat;
    v.gap = gap; v.wbub = wbub; v.hold = hold;
    v.exp_busy = eb; v.exp_rv = erv; v.exp_done = edn;
    return v;
  endfunction

  // array row r holds weight beat W-1-r; lane j sums over rows
  function automatic logic [63:0] dotp(input logic [63:0] x,
                                       input mat_t wm);
    logic [63:0] y;
    logic [63:0] acc;
    y = '0;
    for (int j = 0; j < W; j++) begin
      acc = '0;
      for (int r = 0; r < W; r++)
        acc += 64'(x[DW*r +: DW]) *
               64'(wm[W-1-r][DW*j +: DW]);
      y[DW*j +: DW] = acc[DW-1:0];
    end
    return y;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic build(input vec_t v);
    int n;
    int m;
    int cnt;
    int g;
    int job;
    yq.delete();
    for (int i = 0; i < NA; i++) begin
      cv[i] = 0; cr[i] = CW'($urandom);
      wv[i] = 1; xv[i] = 1;
      wd[i] = rnd64(); xd[i] = rnd64();
      e_wr[i] = 0; e_xr[i] = 0; e_bz[i] = 0;
      e_dn[i] = 0; e_st[i] = 0; e_rv[i] = 0;
      e_a[i] = '0; e_b[i] = '0;
      r_a[i] = '0; r_b[i] = '0; r_rv[i] = 0;
    end
    for (int i = 0; i < W; i++) begin
      bcyc[i] = 0;
      case (v.kind)
        0: wrow[i] = 64'(1) << (DW * (W - 1 - i));
        1: wrow[i] = '1;
        default: wrow[i] = rnd64();
      endcase
    end
    for (int t = 0; t < 8; t++)
      for (int j = 0; j < W; j++)
        case (v.kind)
          0: xrow[t][DW*j +: DW] = DW'(t + 1 + j);
          1: xrow[t][DW*j +: DW] = '1;
          default: xrow[t][DW*j +: DW] = DW'($urandom);
        endcase
    for (int i = 0; i < NA; i++)
      if (v.kind == 2) xv[i] = ($urandom_range(0, 3) != 0);
    cv[0] = 1; cr[0] = CW'(v.k);
    if (v.hold)
      for (int i = 0; i <= 20; i++) begin
        cv[i] = 1; cr[i] = CW'(v.k);
      end
    if (v.wbub != 0) wv[3] = 0;
    // timeline of each job derived from the handshake rules
    n = 0;
    job = 0;
    while (n < N) begin
      if (!cv[n]) begin
        n++;
        continue;
      end
      m = n + 1;
      cnt = 0;
      while (cnt < W && m < N) begin
        e_wr[m] = 1; e_bz[m] = 1;
        if (wv[m]) begin
          wd[m] = wrow[cnt];
          e_b[m+1] = wrow[cnt];
          if (job == 0) bcyc[cnt] = m + 1;
          cnt++;
        end
        m++;
      end
      e_bz[m] = 1;
      m++;
      cnt = 0;
      g = v.gap;
      while (cnt < v.k && m < N) begin
        e_xr[m] = 1; e_bz[m] = 1; e_st[m+1] = 1;
        if (v.kind != 2 && cnt == v.gap_at && g > 0) begin
          xv[m] = 0;
          g--;
        end
        if (xv[m]) begin
          xd[m] = xrow[cnt];
          e_a[m+1] = xrow[cnt];
          e_rv[m+W+2] = 1;
          yq.push_back(dotp(xrow[cnt], wrow));
          cnt++;
        end
        m++;
      end
      for (int f = 0; f < 2 * W; f++) begin
        e_bz[m] = 1; e_st[m+1] = 1;
        m++;
      end
      e_dn[m] = 1;
      n = m;
      job++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cmd_valid = 0; cmd_rows = '0;
    w_valid = 0; w_data = '0;
    x_valid = 0; x_data = '0;
    #3;
    chk("rst cmd_ready", -1, cmd_ready, 1);
    chk("rst w_ready", -1, w_ready, 0);
    chk("rst x_ready", -1, x_ready, 0);
    chk("rst busy", -1, busy, 0);
    chk("rst done", -1, done, 0);
    chk("rst state", -1, state, 0);
    chk("rst res_valid", -1, res_valid, 0);
    chk("rst a_in_raw", -1, a_in_raw, 0);
    chk("rst b_in_raw", -1, b_in_raw, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int s);
    int nrv;
    int nbz;
    int ndn;
    int idx;
    mat_t wm;
    string tag;
    build(v);
    do_reset();
    nrv = 0; nbz = 0; ndn = 0;
    for (int n = 0; n < N; n++) begin
      @(posedge clk);
      #1;
      cmd_valid = cv[n]; cmd_rows = cr[n];
      w_valid = wv[n]; w_data = wd[n];
      x_valid = xv[n]; x_data = xd[n];
      @(negedge clk);
      chk("cmd_ready", n, cmd_ready, !e_bz[n]);
      chk("w_ready", n, w_ready, e_wr[n]);
      chk("x_ready", n, x_ready, e_xr[n]);
      chk("busy", n, busy, e_bz[n]);
      chk("done", n, done, e_dn[n]);
      chk("state", n, state, e_st[n]);
      chk("res_valid", n, res_valid, e_rv[n]);
      chk("a_in_raw", n, a_in_raw, e_a[n]);
      chk("b_in_raw", n, b_in_raw, e_b[n]);
      chk("mode", n, mode, 0);
      chk("sum_in_raw", n, sum_in_raw, 0);
      r_a[n] = a_in_raw; r_b[n] = b_in_raw;
      r_rv[n] = res_valid;
      nrv += int'(res_valid);
      nbz += int'(busy);
      ndn += int'(done);
    end
    cmd_valid = 0; w_valid = 0; x_valid = 0;
    tag = $sformatf("vec%0d", s);
    chk({tag, " rv_count"}, -1, nrv, v.exp_rv);
    chk({tag, " done_count"}, -1, ndn, v.exp_done);
    if (v.exp_busy >= 0)
      chk({tag, " busy_cycles"}, -1, nbz, v.exp_busy);
    for (int i = 0; i < W; i++) wm[i] = r_b[bcyc[i]];
    idx = 0;
    for (int n = W + 1; n < N; n++)
      if (r_rv[n] && idx < yq.size()) begin
        chk({tag, " dot"}, n,
            dotp(r_a[n-W-1], wm), yq[idx]);
        idx++;
      end
  endtask

  task automatic reset_mid_compute();
    do_reset();
    @(posedge clk);
    #1;
    cmd_valid = 1; cmd_rows = CW'(5);
    w_valid = 1; w_data = 64'h0004_0003_0002_0001;
    x_valid = 1; x_data = 64'h0011_0022_0033_0044;
    @(posedge clk);
    #1;
    cmd_valid = 0;
    repeat (7) @(posedge clk);
    #2;
    chk("mid busy", 8, busy, 1);
    chk("mid state", 8, state, 1);
    chk("mid a_in_raw", 8, a_in_raw, x_data);
    rst_n = 1'b0;
    #1;
    chk("abort busy", 8, busy, 0);
    chk("abort state", 8, state, 0);
    chk("abort res_valid", 8, res_valid, 0);
    chk("abort cmd_ready", 8, cmd_ready, 1);
    chk("abort x_ready", 8, x_ready, 0);
    chk("abort a_in_raw", 8, a_in_raw, 0);
    @(posedge clk);
    #1;
    chk("abort+1 busy", 9, busy, 0);
    chk("abort+1 state", 9, state, 0);
    chk("abort+1 res_valid", 9, res_valid, 0);
    chk("abort+1 cmd_ready", 9, cmd_ready, 1);
    x_valid = 0; w_valid = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int k;
    n_cmp = 0;
    n_bad = 0;
    tbl[0] = mk(4, 0, 0, 0, 0, 0, 17, 4, 1);
    tbl[1] = mk(4, 0, 2, 2, 0, 0, 19, 4, 1);
    tbl[2] = mk(0, 0, 0, 0, 0, 0, 13, 0, 1);
    tbl[3] = mk(3, 1, 0, 0, 0, 0, 16, 3, 1);
    tbl[4] = mk(2, 0, 0, 0, 0, 1, 30, 4, 2);
    tbl[5] = mk(2, 0, 0, 0, 1, 0, 16, 2, 1);
    for (int s = 6; s < 8; s++) begin
      k = int'($urandom_range(1, 6));
      tbl[s] = mk(k, 2, 0, 0, 0, 0, -1, k, 1);
    end
    reset_mid_compute();
    for (int s = 0; s < 8; s++) run_vec(tbl[s], s);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
